// File: rtl/state_pkg.sv
// Shared state encodings and helpers for the sequencing FSM and its downstream checker.
package state_pkg;

    localparam int unsigned ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S0      = 4'd0,
        S1      = 4'd1,
        S2      = 4'd2,
        S3      = 4'd3,
        S4      = 4'd4,
        S5      = 4'd5,
        S6      = 4'd6,
        S7      = 4'd7,
        S8      = 4'd8,
        S9      = 4'd9,
        S_ILL10 = 4'd10,
        S_ILL11 = 4'd11,
        S_ILL12 = 4'd12,
        S_ILL13 = 4'd13,
        S14     = 4'd14,
        S_ILL15 = 4'd15
    } state_t;

    localparam state_t ST_RECOV = S4;
    localparam state_t ST_HOME  = S0;

    // Encodings that the legal transition graph never visits.
    function automatic logic is_illegal(input logic [ST_W-1:0] s);
        return (s inside {4'd10, 4'd11, 4'd12, 4'd13, 4'd15});
    endfunction

endpackage

// File: rtl/state_seq_gen_sat_cnt.sv
// Saturating up-counter with synchronous clear.
module sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/state_seq_gen.sv
// Sequencing FSM driving the shared 4-bit state value, with force-load,
// lap counting on sequenced returns to home and a recovery pulse.
module state_seq_gen
    import state_pkg::*;
#(
    parameter int unsigned     LAP_W     = 8,
    parameter logic [ST_W-1:0] RST_STATE = 4'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic             ld_en,
    input  logic [ST_W-1:0]  ld_state,
    output logic [ST_W-1:0]  state,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             recov,
    output logic             illegal
);

    state_t state_q;
    state_t state_d;
    logic   recov_d;
    logic   lap_inc;

    // State and recovery-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= state_t'(RST_STATE);
            recov   <= 1'b0;
        end else begin
            state_q <= state_d;
            recov   <= recov_d;
        end
    end

    // Next state; a load overrides sequencing and suppresses lap/recovery events.
    always_comb begin
        state_d = state_q;
        recov_d = 1'b0;
        lap_inc = 1'b0;
        if (ld_en) begin
            state_d = state_t'(ld_state);
        end else begin
            unique case (state_q)
                S0: state_d = S1;
                S1: state_d = sel[0] ? S4 : S2;
                S2: state_d = S3;
                S3: state_d = sel[0] ? S1 : S5;
                S4: state_d = S5;
                S5: state_d = sel[0] ? S1 : S6;
                S6: state_d = S7;
                S7: begin
                    state_d = sel[0] ? ST_HOME : S8;
                    lap_inc = sel[0];
                end
                S8: begin
                    case (sel)
                        2'b00:   state_d = S2;
                        2'b01:   state_d = S4;
                        2'b10:   state_d = S9;
                        default: state_d = S14;
                    endcase
                end
                S9, S14: begin
                    state_d = ST_HOME;
                    lap_inc = 1'b1;
                end
                default: begin
                    state_d = ST_RECOV;
                    recov_d = 1'b1;
                end
            endcase
        end
    end

    sat_cnt #(
        .W (LAP_W)
    ) u_lap_cnt (
        .clk (clk),
        .clr (rst),
        .inc (lap_inc),
        .cnt (lap_cnt)
    );

    assign state   = state_q;
    assign illegal = is_illegal(state_q);

endmodule

// File: tb/tb_state_seq_gen.sv
// Directed self-checking bench for state_seq_gen (lap counter narrowed to 2 bits).
module tb_state_seq_gen;

    localparam int unsigned LAP_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       sel;
    logic             ld_en;
    logic [3:0]       ld_state;
    logic [3:0]       state;
    logic [LAP_W-1:0] lap_cnt;
    logic             recov;
    logic             illegal;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    state_seq_gen #(
        .LAP_W     (LAP_W),
        .RST_STATE (4'd0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .ld_en    (ld_en),
        .ld_state (ld_state),
        .state    (state),
        .lap_cnt  (lap_cnt),
        .recov    (recov),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock, then check all outputs 1 time unit after the edge.
    task automatic step(input string tag, input logic r, input logic l, input logic [3:0] ls,
                        input logic [1:0] s, input logic [3:0] es, input logic [1:0] el,
                        input logic erc, input logic eil);
        rst      = r;
        ld_en    = l;
        ld_state = ls;
        sel      = s;
        @(posedge clk);
        #1;
        chk({tag, ".state"},   8'(state),   8'(es));
        chk({tag, ".lap"},     8'(lap_cnt), 8'(el));
        chk({tag, ".recov"},   8'(recov),   8'(erc));
        chk({tag, ".illegal"}, 8'(illegal), 8'(eil));
    endtask

    // Normal sequencing step (no reset, no load).
    task automatic seq(input string tag, input logic [1:0] s, input logic [3:0] es,
                       input logic [1:0] el);
        step(tag, 1'b0, 1'b0, 4'd0, s, es, el, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] ill_vals [5];
        logic [3:0] rst_seq  [8];
        logic [1:0] exp_lap;
        ill_vals = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd15};
        rst_seq  = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};

        rst = 1'b1; ld_en = 1'b0; ld_state = 4'd0; sel = 2'b00;
        @(negedge clk);

        // Reset held two cycles, then plain sel=00 walk.
        step("rst0", 1'b1, 1'b0, 4'd0, 2'b00, 4'd0, 2'd0, 1'b0, 1'b0);
        step("rst1", 1'b1, 1'b1, 4'd9, 2'b11, 4'd0, 2'd0, 1'b0, 1'b0);
        foreach (rst_seq[i]) seq("walk", 2'b00, rst_seq[i], 2'd0);

        // Branch coverage, starting from state 2.
        seq("b2_3",   2'b00, 4'd3, 2'd0);
        seq("b3_1",   2'b01, 4'd1, 2'd0);
        seq("b1_4",   2'b01, 4'd4, 2'd0);
        seq("b4_5",   2'b11, 4'd5, 2'd0);
        seq("b5_1",   2'b01, 4'd1, 2'd0);
        seq("b1_2",   2'b00, 4'd2, 2'd0);
        seq("b2_3b",  2'b11, 4'd3, 2'd0);
        seq("b3_5",   2'b00, 4'd5, 2'd0);
        seq("b5_6",   2'b00, 4'd6, 2'd0);
        seq("b6_7",   2'b01, 4'd7, 2'd0);
        seq("b7_0",   2'b01, 4'd0, 2'd1);
        seq("b0_1",   2'b11, 4'd1, 2'd1);
        seq("c1_2",   2'b00, 4'd2, 2'd1);
        seq("c2_3",   2'b00, 4'd3, 2'd1);
        seq("c3_5",   2'b00, 4'd5, 2'd1);
        seq("c5_6",   2'b00, 4'd6, 2'd1);
        seq("c6_7",   2'b00, 4'd7, 2'd1);
        seq("c7_8",   2'b00, 4'd8, 2'd1);
        seq("b8_9",   2'b10, 4'd9, 2'd1);
        seq("b9_0",   2'b11, 4'd0, 2'd2);
        seq("d0_1",   2'b00, 4'd1, 2'd2);
        seq("d1_2",   2'b00, 4'd2, 2'd2);
        seq("d2_3",   2'b00, 4'd3, 2'd2);
        seq("d3_5",   2'b00, 4'd5, 2'd2);
        seq("d5_6",   2'b00, 4'd6, 2'd2);
        seq("d6_7",   2'b00, 4'd7, 2'd2);
        seq("d7_8",   2'b00, 4'd8, 2'd2);
        seq("b8_14",  2'b11, 4'd14, 2'd2);
        seq("b14_0",  2'b00, 4'd0, 2'd3);
        seq("e0_1",   2'b00, 4'd1, 2'd3);
        seq("e1_2",   2'b00, 4'd2, 2'd3);
        seq("e2_3",   2'b00, 4'd3, 2'd3);
        seq("e3_5",   2'b00, 4'd5, 2'd3);
        seq("e5_6",   2'b00, 4'd6, 2'd3);
        seq("e6_7",   2'b00, 4'd7, 2'd3);
        seq("e7_8",   2'b00, 4'd8, 2'd3);
        seq("b8_4",   2'b01, 4'd4, 2'd3);

        // Illegal-encoding recovery.
        foreach (ill_vals[i]) begin
            step("ill_ld",  1'b0, 1'b1, ill_vals[i], 2'b00, ill_vals[i], 2'd3, 1'b0, 1'b1);
            step("ill_rec", 1'b0, 1'b0, 4'd0,        2'b11, 4'd4,        2'd3, 1'b1, 1'b0);
            step("ill_nxt", 1'b0, 1'b0, 4'd0,        2'b00, 4'd5,        2'd3, 1'b0, 1'b0);
        end

        // Priority: load beats lap and recovery edges; reset beats load.
        step("p_rst",  1'b1, 1'b0, 4'd0, 2'b00, 4'd0, 2'd0, 1'b0, 1'b0);
        seq("p0_1",   2'b00, 4'd1, 2'd0);
        seq("p1_2",   2'b00, 4'd2, 2'd0);
        seq("p2_3",   2'b00, 4'd3, 2'd0);
        seq("p3_5",   2'b00, 4'd5, 2'd0);
        seq("p5_6",   2'b00, 4'd6, 2'd0);
        seq("p6_7",   2'b00, 4'd7, 2'd0);
        step("p_ld7",  1'b0, 1'b1, 4'd3,  2'b01, 4'd3,  2'd0, 1'b0, 1'b0);
        step("p_ld0",  1'b0, 1'b1, 4'd0,  2'b00, 4'd0,  2'd0, 1'b0, 1'b0);
        step("p_ld4",  1'b0, 1'b1, 4'd4,  2'b00, 4'd4,  2'd0, 1'b0, 1'b0);
        step("p_ld12", 1'b0, 1'b1, 4'd12, 2'b00, 4'd12, 2'd0, 1'b0, 1'b1);
        step("p_ldrc", 1'b0, 1'b1, 4'd2,  2'b00, 4'd2,  2'd0, 1'b0, 1'b0);
        seq("p2_3b",  2'b00, 4'd3, 2'd0);
        seq("p3_5b",  2'b00, 4'd5, 2'd0);
        seq("p5_6b",  2'b00, 4'd6, 2'd0);
        seq("p6_7b",  2'b00, 4'd7, 2'd0);
        seq("p7_0",   2'b01, 4'd0, 2'd1);
        seq("q0_1",   2'b00, 4'd1, 2'd1);
        seq("q1_2",   2'b00, 4'd2, 2'd1);
        seq("q2_3",   2'b00, 4'd3, 2'd1);
        seq("q3_5",   2'b00, 4'd5, 2'd1);
        seq("q5_6",   2'b00, 4'd6, 2'd1);
        seq("q6_7",   2'b00, 4'd7, 2'd1);
        seq("q7_8",   2'b00, 4'd8, 2'd1);
        step("p_rstld", 1'b1, 1'b1, 4'd9, 2'b10, 4'd0, 2'd0, 1'b0, 1'b0);

        // Saturation over five laps.
        exp_lap = 2'd0;
        for (int k = 0; k < 5; k++) begin
            seq("s0_1", 2'b00, 4'd1, exp_lap);
            seq("s1_2", 2'b00, 4'd2, exp_lap);
            seq("s2_3", 2'b00, 4'd3, exp_lap);
            seq("s3_5", 2'b00, 4'd5, exp_lap);
            seq("s5_6", 2'b00, 4'd6, exp_lap);
            seq("s6_7", 2'b00, 4'd7, exp_lap);
            if (exp_lap != 2'd3) exp_lap = exp_lap + 2'd1;
            seq("s7_0", 2'b01, 4'd0, exp_lap);
        end

        // Reset mid-operation from state 6.
        seq("m0_1", 2'b00, 4'd1, 2'd3);
        seq("m1_2", 2'b00, 4'd2, 2'd3);
        seq("m2_3", 2'b00, 4'd3, 2'd3);
        seq("m3_5", 2'b00, 4'd5, 2'd3);
        seq("m5_6", 2'b00, 4'd6, 2'd3);
        step("m_rst", 1'b1, 1'b0, 4'd0, 2'b01, 4'd0, 2'd0, 1'b0, 1'b0);
        seq("m0_1b", 2'b01, 4'd1, 2'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
